// File: rtl/bldc_hall_commutator.sv
// Trapezoidal BLDC commutator: filtered hall decode, sector offset, direction/position
// tracking, hall-period measurement with stall flag, sticky fault with explicit clear.
//
// state    | meaning
// ACQUIRE  | outputs zero, waiting for a stable valid hall pattern to lock onto
// RUN      | driving U/V per sector table, tracking steps and period
// FAULT    | illegal pattern or sector jump seen; outputs zero until err_clr
module bldc_hall_commutator #(
    parameter int REG_SIZE      = 16,
    parameter int FILT_CYCLES   = 8,
    parameter int SECTOR_OFFSET = 0,
    parameter int POS_W         = 32,
    parameter int PER_W         = 24,
    parameter int STALL_CYCLES  = 2**20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                err_clr,
    input  logic                hall_1,
    input  logic                hall_2,
    input  logic                hall_3,
    input  logic [REG_SIZE-1:0] current_in,
    output logic [REG_SIZE-1:0] current_out_U,
    output logic [REG_SIZE-1:0] current_out_V,
    output logic [2:0]          sector,
    output logic                direction,
    output logic [POS_W-1:0]    position,
    output logic [PER_W-1:0]    hall_period,
    output logic                stall,
    output logic                hall_error
);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    localparam logic [7:0]          FILT_N   = 8'(FILT_CYCLES);
    localparam logic [31:0]         STALL_TH = 32'(STALL_CYCLES);
    localparam logic [REG_SIZE-1:0] MIN_NEG  = {1'b1, {(REG_SIZE-1){1'b0}}};
    localparam logic [REG_SIZE-1:0] MAX_POS  = {1'b0, {(REG_SIZE-1){1'b1}}};
    localparam logic [REG_SIZE-1:0] ONE_R    = REG_SIZE'(1);

    logic [2:0]          sync1_q, sync2_q;
    logic [1:0]          warm_q;
    logic [2:0]          cand_q;
    logic [7:0]          fcnt_q, fcnt_d;
    logic                same, fire, stable;

    logic [1:0]          state_q, state_d;
    logic [2:0]          sector_q, sector_d;
    logic                dir_q, dir_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d, per_inc;
    logic                err_q, err_d;
    logic [REG_SIZE-1:0] u_q, u_d, v_q, v_d;

    logic                pat_valid, fault;
    logic [2:0]          raw_sec, new_sec, sec_inc, sec_dec;
    logic [3:0]          sec_sum;
    logic [REG_SIZE-1:0] neg_i;

    // Sync registers start at 000 after reset; warm_q keeps that artefact out of the filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            warm_q  <= 2'b00;
            cand_q  <= 3'b000;
            fcnt_q  <= 8'd0;
        end else begin
            sync1_q <= {hall_1, hall_2, hall_3};
            sync2_q <= sync1_q;
            warm_q  <= {warm_q[0], 1'b1};
            if (warm_q[1]) begin
                cand_q <= sync2_q;
                fcnt_q <= fcnt_d;
            end
        end
    end

    always_comb begin
        same   = (sync2_q == cand_q);
        fcnt_d = !same ? 8'd1 : ((fcnt_q == FILT_N) ? FILT_N : fcnt_q + 8'd1);
        // fire: pattern just completed its stable run; stable: it had already done so
        fire   = warm_q[1] && (fcnt_d == FILT_N) && !(same && (fcnt_q == FILT_N));
        stable = warm_q[1] && same && (fcnt_q == FILT_N);
    end

    always_comb begin
        pat_valid = 1'b1;
        raw_sec   = 3'd0;
        case (sync2_q)
            3'b100:  raw_sec = 3'd0;
            3'b110:  raw_sec = 3'd1;
            3'b010:  raw_sec = 3'd2;
            3'b011:  raw_sec = 3'd3;
            3'b001:  raw_sec = 3'd4;
            3'b101:  raw_sec = 3'd5;
            default: pat_valid = 1'b0;
        endcase
        sec_sum = {1'b0, raw_sec} + 4'(SECTOR_OFFSET);
        new_sec = (sec_sum >= 4'd6) ? 3'(sec_sum - 4'd6) : sec_sum[2:0];
        sec_inc = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        sec_dec = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
        per_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PER_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        sector_d  = sector_q;
        dir_d     = dir_q;
        pos_d     = pos_q;
        per_d     = per_q;
        per_cnt_d = (state_q == ST_RUN) ? per_inc : '0;
        err_d     = err_q;
        fault     = 1'b0;
        if (!enable) begin
            state_d   = ST_ACQUIRE;
            per_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ACQUIRE: begin
                    if (fire || stable) begin
                        if (pat_valid) begin
                            state_d  = ST_RUN;
                            sector_d = new_sec;
                        end else begin
                            fault = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fire) begin
                        if (!pat_valid) begin
                            fault = 1'b1;
                        end else if (new_sec == sec_inc) begin
                            sector_d  = new_sec;
                            dir_d     = 1'b1;
                            pos_d     = pos_q + POS_W'(1);
                            per_d     = per_inc;
                            per_cnt_d = '0;
                        end else if (new_sec == sec_dec) begin
                            sector_d  = new_sec;
                            dir_d     = 1'b0;
                            pos_d     = pos_q - POS_W'(1);
                            per_d     = per_inc;
                            per_cnt_d = '0;
                        end else if (new_sec != sector_q) begin
                            fault = 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (err_clr) state_d = ST_ACQUIRE;
                end
                default: state_d = ST_ACQUIRE;
            endcase
            if (fault) begin
                state_d   = ST_FAULT;
                per_cnt_d = '0;
            end
            err_d = fault ? 1'b1 : (err_clr ? 1'b0 : err_q);
        end
    end

    always_comb begin
        neg_i = (current_in == MIN_NEG) ? MAX_POS : (~current_in + ONE_R);
        u_d   = '0;
        v_d   = '0;
        if (enable && (state_q == ST_RUN)) begin
            case (sector_q)
                3'd0: begin u_d = neg_i;      v_d = current_in; end
                3'd1: begin u_d = '0;         v_d = current_in; end
                3'd2: begin u_d = current_in; v_d = '0;         end
                3'd3: begin u_d = current_in; v_d = neg_i;      end
                3'd4: begin u_d = '0;         v_d = neg_i;      end
                3'd5: begin u_d = neg_i;      v_d = '0;         end
                default: begin u_d = '0;      v_d = '0;         end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ACQUIRE;
            sector_q  <= 3'd0;
            dir_q     <= 1'b0;
            pos_q     <= '0;
            per_q     <= '0;
            per_cnt_q <= '0;
            err_q     <= 1'b0;
            u_q       <= '0;
            v_q       <= '0;
        end else begin
            state_q   <= state_d;
            sector_q  <= sector_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            per_q     <= per_d;
            per_cnt_q <= per_cnt_d;
            err_q     <= err_d;
            u_q       <= u_d;
            v_q       <= v_d;
        end
    end

    assign current_out_U = u_q;
    assign current_out_V = v_q;
    assign sector        = sector_q;
    assign direction     = dir_q;
    assign position      = pos_q;
    assign hall_period   = per_q;
    assign hall_error    = err_q;
    assign stall         = (state_q == ST_RUN) && (32'(per_cnt_q) >= STALL_TH);

endmodule

// File: tb/tb_bldc_hall_commutator.sv
// Directed bench for bldc_hall_commutator: latency, sector table, stepping, glitch
// filtering, faults, saturation, stall and enable handling.
module tb_bldc_hall_commutator;

    logic               clk, rst, enable, err_clr;
    logic               hall_1, hall_2, hall_3;
    logic signed [15:0] cur_in, cu, cv;
    logic [2:0]         sec;
    logic               dir, stl, err;
    logic signed [31:0] pos;
    logic [7:0]         per;

    int errors = 0;
    int checks = 0;

    bldc_hall_commutator #(
        .REG_SIZE(16), .FILT_CYCLES(8), .SECTOR_OFFSET(0),
        .POS_W(32), .PER_W(8), .STALL_CYCLES(200)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
        .hall_1(hall_1), .hall_2(hall_2), .hall_3(hall_3),
        .current_in(cur_in), .current_out_U(cu), .current_out_V(cv),
        .sector(sec), .direction(dir), .position(pos), .hall_period(per),
        .stall(stl), .hall_error(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hall(input logic [2:0] p);
        {hall_1, hall_2, hall_3} = p;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1; err_clr = 1'b0; cur_in = 16'sd1000;
        set_hall(3'b100);
        tick(3);
        checks++; if (cu !== 0 || cv !== 0) begin errors++; $display("FAIL reset_uv: got U=%0d V=%0d expected 0 0", cu, cv); end
        checks++; if (pos !== 0 || per !== 0 || sec !== 0) begin errors++; $display("FAIL reset_regs: got pos=%0d per=%0d sec=%0d expected 0 0 0", pos, per, sec); end
        checks++; if (err !== 0 || stl !== 0 || dir !== 0) begin errors++; $display("FAIL reset_flags: got err=%0b stall=%0b dir=%0b expected 0", err, stl, dir); end
        rst = 1'b0;
        tick(10);
        checks++; if (cu !== 0) begin errors++; $display("FAIL latency_early: got U=%0d expected 0", cu); end
        tick(1);
        checks++; if (cu !== -1000 || cv !== 1000) begin errors++; $display("FAIL latency_u_v: got U=%0d V=%0d expected -1000 1000", cu, cv); end
        checks++; if (sec !== 0 || err !== 0) begin errors++; $display("FAIL acquire: got sec=%0d err=%0b expected 0 0", sec, err); end
    endtask

    task automatic test_forward;
        logic [2:0] pats[6]  = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
        int         secs[6]  = '{1, 2, 3, 4, 5, 0};
        int         eu[6]    = '{0, 1000, 1000, 0, -1000, -1000};
        int         ev[6]    = '{1000, 0, -1000, -1000, 0, 1000};
        for (int i = 0; i < 6; i++) begin
            set_hall(pats[i]);
            tick(50);
            checks++;
            if (sec !== 3'(secs[i]) || cu !== eu[i] || cv !== ev[i]) begin
                errors++;
                $display("FAIL fwd_step%0d: got sec=%0d U=%0d V=%0d expected sec=%0d U=%0d V=%0d", i, sec, cu, cv, secs[i], eu[i], ev[i]);
            end
        end
        checks++; if (pos !== 6 || dir !== 1'b1) begin errors++; $display("FAIL fwd_pos: got pos=%0d dir=%0b expected 6 1", pos, dir); end
        checks++; if (per !== 8'd50) begin errors++; $display("FAIL fwd_period: got %0d expected 50", per); end
        set_hall(3'b101);
        tick(50);
        checks++; if (pos !== 5 || dir !== 1'b0 || sec !== 3'd5) begin errors++; $display("FAIL rev_step: got pos=%0d dir=%0b sec=%0d expected 5 0 5", pos, dir, sec); end
        checks++; if (cu !== -1000 || cv !== 0) begin errors++; $display("FAIL rev_uv: got U=%0d V=%0d expected -1000 0", cu, cv); end
        set_hall(3'b100);
        tick(50);
        checks++; if (pos !== 6 || dir !== 1'b1) begin errors++; $display("FAIL rev_back: got pos=%0d dir=%0b expected 6 1", pos, dir); end
    endtask

    task automatic test_glitch;
        set_hall(3'b110);
        tick(7);
        set_hall(3'b100);
        tick(50);
        checks++; if (sec !== 0 || pos !== 6 || err !== 0) begin errors++; $display("FAIL glitch_short: got sec=%0d pos=%0d err=%0b expected 0 6 0", sec, pos, err); end
        set_hall(3'b110);
        tick(8);
        set_hall(3'b100);
        tick(4);
        checks++; if (sec !== 1 || pos !== 7 || cu !== 0 || cv !== 1000) begin errors++; $display("FAIL glitch_accept: got sec=%0d pos=%0d U=%0d V=%0d expected 1 7 0 1000", sec, pos, cu, cv); end
        tick(46);
        checks++; if (sec !== 0 || pos !== 6 || dir !== 1'b0) begin errors++; $display("FAIL glitch_return: got sec=%0d pos=%0d dir=%0b expected 0 6 0", sec, pos, dir); end
        checks++; if (per !== 8'd8) begin errors++; $display("FAIL glitch_period: got %0d expected 8", per); end
    endtask

    task automatic test_saturate_current;
        cur_in = 16'sh8000;
        tick(1);
        checks++; if (cu !== 32767 || cv !== -32768) begin errors++; $display("FAIL neg_sat: got U=%0d V=%0d expected 32767 -32768", cu, cv); end
        cur_in = 16'sd500;
        tick(1);
        checks++; if (cu !== -500 || cv !== 500) begin errors++; $display("FAIL cur_latency: got U=%0d V=%0d expected -500 500", cu, cv); end
    endtask

    task automatic test_stall_enable;
        cur_in = 16'sd1000;
        set_hall(3'b110);
        tick(209);
        checks++; if (stl !== 1'b0) begin errors++; $display("FAIL stall_early: got %0b expected 0", stl); end
        tick(1);
        checks++; if (stl !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL stall_set: got stall=%0b err=%0b expected 1 0", stl, err); end
        tick(100);
        set_hall(3'b010);
        tick(12);
        checks++; if (stl !== 1'b0 || per !== 8'd255) begin errors++; $display("FAIL stall_clear: got stall=%0b per=%0d expected 0 255", stl, per); end
        checks++; if (sec !== 2 || pos !== 8 || cu !== 1000 || cv !== 0) begin errors++; $display("FAIL stall_step: got sec=%0d pos=%0d U=%0d V=%0d expected 2 8 1000 0", sec, pos, cu, cv); end
        enable = 1'b0;
        tick(1);
        checks++; if (cu !== 0 || cv !== 0 || pos !== 8 || per !== 8'd255) begin errors++; $display("FAIL disable: got U=%0d V=%0d pos=%0d per=%0d expected 0 0 8 255", cu, cv, pos, per); end
        tick(20);
        enable = 1'b1;
        tick(3);
        checks++; if (cu !== 1000 || sec !== 2 || pos !== 8) begin errors++; $display("FAIL reenable: got U=%0d sec=%0d pos=%0d expected 1000 2 8", cu, sec, pos); end
    endtask

    task automatic test_fault;
        set_hall(3'b110);
        tick(50);
        set_hall(3'b100);
        tick(50);
        checks++; if (pos !== 6 || sec !== 0) begin errors++; $display("FAIL pre_fault: got pos=%0d sec=%0d expected 6 0", pos, sec); end
        set_hall(3'b011);
        tick(12);
        checks++; if (err !== 1'b1 || cu !== 0 || cv !== 0 || pos !== 6) begin errors++; $display("FAIL jump_fault: got err=%0b U=%0d V=%0d pos=%0d expected 1 0 0 6", err, cu, cv, pos); end
        tick(30);
        checks++; if (err !== 1'b1 || cu !== 0) begin errors++; $display("FAIL fault_hold: got err=%0b U=%0d expected 1 0", err, cu); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %0b expected 0", err); end
        tick(4);
        checks++; if (sec !== 3 || cu !== 1000 || cv !== -1000 || pos !== 6) begin errors++; $display("FAIL reacquire: got sec=%0d U=%0d V=%0d pos=%0d expected 3 1000 -1000 6", sec, cu, cv, pos); end
        set_hall(3'b111);
        tick(9);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_wins: got err=%0b expected 1", err); end
        tick(1);
        checks++; if (cu !== 0 || cv !== 0) begin errors++; $display("FAIL invalid_uv: got U=%0d V=%0d expected 0 0", cu, cv); end
        set_hall(3'b100);
        tick(20);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(4);
        checks++; if (err !== 1'b0 || sec !== 0 || cu !== -1000 || cv !== 1000) begin errors++; $display("FAIL recover: got err=%0b sec=%0d U=%0d V=%0d expected 0 0 -1000 1000", err, sec, cu, cv); end
    endtask

    task automatic test_mid_reset;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (cu !== 0 || cv !== 0 || pos !== 0 || per !== 0 || err !== 0 || sec !== 0) begin errors++; $display("FAIL mid_reset: got U=%0d V=%0d pos=%0d per=%0d err=%0b sec=%0d expected all 0", cu, cv, pos, per, err, sec); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_glitch();
        test_saturate_current();
        test_stall_enable();
        test_fault();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
